// File: rtl/clk_period_meter.sv
// Measures the rising-to-rising period of a slow asynchronous clock in clk_50mhz cycles.
// Optional min/max period tracking is enabled by defining CLK_METER_MINMAX_EN.
module clk_period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk_50mhz,
    input  logic             rst_50mhz,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             stalled,
    output logic [15:0]      edge_cnt
`ifdef CLK_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam logic [63:0] TO_LAST = 64'(TIMEOUT) - 64'd1;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             sync_p0;
    logic             sync_p1;
    logic             sync_p2;
    logic             rise_p3;
    logic [63:0]      cnt_ext;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cnt_ext  = 64'(counter);
    assign cnt_next = sat_inc(counter);

    always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz) begin
            state        <= IDLE;
            counter      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            edge_cnt     <= '0;
            sync_p0      <= 1'b0;
            sync_p1      <= 1'b0;
            sync_p2      <= 1'b0;
            rise_p3      <= 1'b0;
`ifdef CLK_METER_MINMAX_EN
            period_min   <= '1;
            period_max   <= '0;
`endif
        end else begin
            // synchronizer, edge-history flop, then registered rising-edge strobe
            sync_p0      <= clk_in;
            sync_p1      <= sync_p0;
            sync_p2      <= sync_p1;
            rise_p3      <= sync_p1 & ~sync_p2;
            period_valid <= 1'b0;

            if (rise_p3) begin
                edge_cnt <= edge_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    counter <= '0;
                    if (rise_p3) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // a rise coinciding with the timeout still completes the measurement
                    if (rise_p3) begin
                        period       <= cnt_next;
                        period_valid <= 1'b1;
                        counter      <= '0;
`ifdef CLK_METER_MINMAX_EN
                        if (cnt_next < period_min) period_min <= cnt_next;
                        if (cnt_next > period_max) period_max <= cnt_next;
`endif
                    end else if (cnt_ext == TO_LAST) begin
                        state   <= STALL;
                        stalled <= 1'b1;
                    end else begin
                        counter <= cnt_next;
                    end
                end
                STALL: begin
                    // first edge after a stall only re-arms the measurement
                    if (rise_p3) begin
                        state   <= MEASURE;
                        counter <= '0;
                        stalled <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule
